// File: rtl/alu_arbiter_pkg.sv
// Shared alu function encodings, arbiter response ids and the response-slot state type.
package alu_arbiter_pkg;

  localparam int ALU_FUNCT_WIDTH = 4;

  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_ADD = 4'd0;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_SUB = 4'd1;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_AND = 4'd2;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_OR  = 4'd3;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_XOR = 4'd4;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_SLT = 4'd5;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_SLL = 4'd6;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_SRL = 4'd7;

  localparam logic ARB_ID_EXEC   = 1'b0;
  localparam logic ARB_ID_BRANCH = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational alu: z = funct(x, y) plus equal/zero/overflow flags.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]               x,
  input  logic [N-1:0]               y,
  input  logic [ALU_FUNCT_WIDTH-1:0] funct,
  output logic [N-1:0]               z,
  output logic                       equal,
  output logic                       zero,
  output logic                       overflow
);

  localparam int SH_W = $clog2(N);

  logic signed [N-1:0] xs;
  logic signed [N-1:0] ys;
  logic signed [N-1:0] sum;
  logic signed [N-1:0] diff;
  logic [SH_W-1:0]     shamt;

  assign xs    = x;
  assign ys    = y;
  assign sum   = xs + ys;
  assign diff  = xs - ys;
  assign shamt = y[SH_W-1:0];

  // Overflow is the two's-complement signed overflow of ADD/SUB; other functions never flag it.
  always_comb begin
    z        = '0;
    overflow = 1'b0;
    case (funct)
      FN_ADD: begin
        z        = sum;
        overflow = (xs[N-1] == ys[N-1]) && (sum[N-1] != xs[N-1]);
      end
      FN_SUB: begin
        z        = diff;
        overflow = (xs[N-1] != ys[N-1]) && (diff[N-1] != xs[N-1]);
      end
      FN_AND:  z = x & y;
      FN_OR:   z = x | y;
      FN_XOR:  z = x ^ y;
      FN_SLT:  z = {{(N-1){1'b0}}, (xs < ys)};
      FN_SLL:  z = x << shamt;
      FN_SRL:  z = x >> shamt;
      default: z = '0;
    endcase
  end

  assign equal = (x == y);
  assign zero  = (z == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between the execute stage (port 0) and the
// branch/address unit (port 1); results return through a single registered response slot.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [N-1:0]               req0_x,
  input  logic [N-1:0]               req0_y,
  input  logic [ALU_FUNCT_WIDTH-1:0] req0_funct,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [N-1:0]               req1_x,
  input  logic [N-1:0]               req1_y,
  input  logic [ALU_FUNCT_WIDTH-1:0] req1_funct,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       resp_id,
  output logic [N-1:0]               resp_z,
  output logic                       resp_equal,
  output logic                       resp_zero,
  output logic                       resp_overflow
);

  arb_state_e                 state_p1;
  arb_state_e                 state_nxt;
  logic                       ptr_p1;
  logic                       id_p1;
  logic [N-1:0]               z_p1;
  logic                       equal_p1;
  logic                       zero_p1;
  logic                       ovf_p1;

  logic                       free_p0;
  logic                       grant0_p0;
  logic                       grant1_p0;
  logic                       grant_p0;
  logic                       gid_p0;
  logic [N-1:0]               x_p0;
  logic [N-1:0]               y_p0;
  logic [ALU_FUNCT_WIDTH-1:0] funct_p0;
  logic [N-1:0]               z_p0;
  logic                       equal_p0;
  logic                       zero_p0;
  logic                       ovf_p0;

  // Stage p0: arbitration and operand mux. Readys are masked during reset so no
  // handshake completes in a reset cycle.
  assign free_p0   = (state_p1 == ST_EMPTY) || resp_ready;
  assign grant0_p0 = !rst && free_p0 && req0_valid && (!req1_valid || ptr_p1 == ARB_ID_EXEC);
  assign grant1_p0 = !rst && free_p0 && req1_valid && (!req0_valid || ptr_p1 == ARB_ID_BRANCH);
  assign grant_p0  = grant0_p0 || grant1_p0;
  assign gid_p0    = grant1_p0 ? ARB_ID_BRANCH : ARB_ID_EXEC;

  assign req0_ready = grant0_p0;
  assign req1_ready = grant1_p0;

  assign x_p0     = grant1_p0 ? req1_x     : req0_x;
  assign y_p0     = grant1_p0 ? req1_y     : req0_y;
  assign funct_p0 = grant1_p0 ? req1_funct : req0_funct;

  alu_arbiter_alu #(.N(N)) u_alu (
    .x        (x_p0),
    .y        (y_p0),
    .funct    (funct_p0),
    .z        (z_p0),
    .equal    (equal_p0),
    .zero     (zero_p0),
    .overflow (ovf_p0)
  );

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      ST_EMPTY: if (grant_p0) state_nxt = ST_FULL;
      ST_FULL:  if (resp_ready && !grant_p0) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_p1 <= ST_EMPTY;
    else     state_p1 <= state_nxt;
  end

  // Stage p1: response register; a grant reloads it even while the old result drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p1   <= ARB_ID_EXEC;
      id_p1    <= ARB_ID_EXEC;
      z_p1     <= '0;
      equal_p1 <= 1'b0;
      zero_p1  <= 1'b0;
      ovf_p1   <= 1'b0;
    end else if (grant_p0) begin
      ptr_p1   <= ~gid_p0;
      id_p1    <= gid_p0;
      z_p1     <= z_p0;
      equal_p1 <= equal_p0;
      zero_p1  <= zero_p0;
      ovf_p1   <= ovf_p0;
    end
  end

  assign resp_valid    = (state_p1 == ST_FULL);
  assign resp_id       = id_p1;
  assign resp_z        = z_p1;
  assign resp_equal    = equal_p1;
  assign resp_zero     = zero_p1;
  assign resp_overflow = ovf_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single-op vector table, then round-robin,
// backpressure and mid-operation reset sequences.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_x, req0_y;
  logic [3:0]  req0_funct;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_x, req1_y;
  logic [3:0]  req1_funct;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_z;
  logic        resp_equal, resp_zero, resp_overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_arbiter #(.N(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_x        (req0_x),
    .req0_y        (req0_y),
    .req0_funct    (req0_funct),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_x        (req1_x),
    .req1_y        (req1_y),
    .req1_funct    (req1_funct),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_z        (resp_z),
    .resp_equal    (resp_equal),
    .resp_zero     (resp_zero),
    .resp_overflow (resp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Requester obligation: a raised valid holds with stable operands until ready.
  logic        pend0, pend1;
  logic [31:0] hx0, hy0, hx1, hy1;
  logic [3:0]  hf0, hf1;
  always @(posedge clk) begin
    if (rst) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else begin
      if (pend0)
        assert (req0_valid && req0_x == hx0 && req0_y == hy0 && req0_funct == hf0)
          else $error("requester 0 changed its operation before ready");
      if (pend1)
        assert (req1_valid && req1_x == hx1 && req1_y == hy1 && req1_funct == hf1)
          else $error("requester 1 changed its operation before ready");
      pend0 <= req0_valid && !req0_ready;
      pend1 <= req1_valid && !req1_ready;
    end
    hx0 <= req0_x; hy0 <= req0_y; hf0 <= req0_funct;
    hx1 <= req1_x; hy1 <= req1_y; hf1 <= req1_funct;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  f;
    logic [31:0] z;
    logic        eq;
    logic        zr;
    logic        ov;
  } vec_t;

  vec_t vt [12];

  logic        mptr;
  logic [31:0] a0, b1, lz, ez;
  logic        lid;

  initial begin
    vt[0]  = '{1'b0, 32'd5,          32'd7,          FN_ADD, 32'd12,         1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 32'd3,          32'd3,          FN_SUB, 32'd0,          1'b1, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 32'h7FFF_FFFF,  32'd1,          FN_ADD, 32'h8000_0000,  1'b0, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 32'h8000_0000,  32'd1,          FN_SUB, 32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 32'h0000_F0F0,  32'h0000_0FF0,  FN_AND, 32'h0000_00F0,  1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 32'h0000_F000,  32'h0000_000F,  FN_OR,  32'h0000_F00F,  1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  FN_XOR, 32'h0000_0000,  1'b1, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 32'hFFFF_FFFF,  32'd1,          FN_SLT, 32'd1,          1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 32'd1,          32'd31,         FN_SLL, 32'h8000_0000,  1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 32'h8000_0000,  32'd4,          FN_SRL, 32'h0800_0000,  1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          FN_ADD, 32'h0000_0000,  1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b1, 32'd0,          32'd1,          FN_SUB, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_funct = FN_ADD;
    req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_funct = FN_ADD;
    resp_ready = 1'b1;

    // Reset for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_id",    {31'd0, resp_id},    32'd0);
    chk("rst_resp_z",     resp_z,              32'd0);
    chk("rst_flags",      {29'd0, resp_equal, resp_zero, resp_overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_ready0", {31'd0, req0_ready}, 32'd0);
    chk("idle_ready1", {31'd0, req1_ready}, 32'd0);

    // Lone-requester vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req0_valid = (vt[i].port == 1'b0);
      req1_valid = (vt[i].port == 1'b1);
      if (vt[i].port == 1'b0) begin
        req0_x = vt[i].x; req0_y = vt[i].y; req0_funct = vt[i].f;
      end else begin
        req1_x = vt[i].x; req1_y = vt[i].y; req1_funct = vt[i].f;
      end
      #1;
      chk($sformatf("v%0d_ready0", i), {31'd0, req0_ready}, {31'd0, !vt[i].port});
      chk($sformatf("v%0d_ready1", i), {31'd0, req1_ready}, {31'd0, vt[i].port});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("v%0d_id", i),    {31'd0, resp_id},    {31'd0, vt[i].port});
      chk($sformatf("v%0d_z", i),     resp_z,              vt[i].z);
      chk($sformatf("v%0d_flags", i), {29'd0, resp_equal, resp_zero, resp_overflow},
          {29'd0, vt[i].eq, vt[i].zr, vt[i].ov});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Reset so the round-robin run starts from ptr 0
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Both requesters valid every cycle: grants alternate with one response per cycle
    mptr = 1'b0;
    a0 = 32'd1;
    b1 = 32'd2;
    req0_valid = 1'b1; req0_funct = FN_ADD; req0_x = a0; req0_y = 32'd10;
    req1_valid = 1'b1; req1_funct = FN_SUB; req1_x = 32'd100; req1_y = b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      req0_x = a0;
      req1_y = b1;
      #1;
      chk($sformatf("rr%0d_ready0", i), {31'd0, req0_ready}, {31'd0, (mptr == 1'b0)});
      chk($sformatf("rr%0d_ready1", i), {31'd0, req1_ready}, {31'd0, (mptr == 1'b1)});
      ez = (mptr == 1'b0) ? (a0 + 32'd10) : (32'd100 - b1);
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_valid", i), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("rr%0d_id", i),    {31'd0, resp_id},    {31'd0, mptr});
      chk($sformatf("rr%0d_z", i),     resp_z,              ez);
      lid = mptr;
      lz  = ez;
      if (mptr == 1'b0) a0 = a0 + 32'd1;
      else              b1 = b1 + 32'd1;
      mptr = ~mptr;
    end

    // Backpressure: response held and no grants while resp_ready is low
    @(negedge clk);
    req0_x = a0;
    req1_y = b1;
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      chk($sformatf("bp%0d_ready0", i), {31'd0, req0_ready}, 32'd0);
      chk($sformatf("bp%0d_ready1", i), {31'd0, req1_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_valid", i), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp%0d_id", i),    {31'd0, resp_id},    {31'd0, lid});
      chk($sformatf("bp%0d_z", i),     resp_z,              lz);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    chk("bp_rel_ready0", {31'd0, req0_ready}, {31'd0, (mptr == 1'b0)});
    chk("bp_rel_ready1", {31'd0, req1_ready}, {31'd0, (mptr == 1'b1)});
    ez = (mptr == 1'b0) ? (a0 + 32'd10) : (32'd100 - b1);
    @(posedge clk);
    #1;
    chk("bp_rel_valid", {31'd0, resp_valid}, 32'd1);
    chk("bp_rel_id",    {31'd0, resp_id},    {31'd0, mptr});
    chk("bp_rel_z",     resp_z,              ez);
    if (mptr == 1'b0) a0 = a0 + 32'd1;
    else              b1 = b1 + 32'd1;

    // Reset while a response is held and both requesters are waiting
    @(negedge clk);
    req0_x = a0;
    req1_y = b1;
    rst = 1'b1;
    #1;
    chk("mrst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("mrst_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("mrst_valid", {31'd0, resp_valid}, 32'd0);
    chk("mrst_z",     resp_z,              32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_id", {31'd0, resp_id}, 32'd0);
    chk("post_rst_z",  resp_z,           a0 + 32'd10);

    // Port 1 then completes alone, then the slot drains with no grant
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("lone1_ready1", {31'd0, req1_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("lone1_id", {31'd0, resp_id}, 32'd1);
    chk("lone1_z",  resp_z,           32'd100 - b1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_valid", {31'd0, resp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
